// File: rtl/int_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : int_sequencer
//  Description : Interrupt front-end. Latches the external interrupt, waits
//                for a hazard-free instruction boundary, then sequences entry
//                (CALL-path push, flag save, vector fetch, PC load). Tracks
//                handler residency until RTI and restores the saved flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module int_sequencer #(
    parameter int PC_W        = 32,
    parameter int FLAG_W      = 4,
    parameter int VECTOR_ADDR = 1,
    parameter int VEC_LAT     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              intr_in,
    input  logic              instr_boundary,
    input  logic              ctrl_hazard,
    input  logic              rti_commit,
    input  logic [PC_W-1:0]   pc_in,
    input  logic [FLAG_W-1:0] flags_in,
    input  logic [PC_W-1:0]   mem_rdata,
    output logic              is_hardware_int,
    output logic [PC_W-1:0]   saved_pc,
    output logic              stall_fetch,
    output logic              mem_rd,
    output logic [PC_W-1:0]   mem_addr,
    output logic              pc_load,
    output logic [PC_W-1:0]   pc_load_val,
    output logic              flags_restore,
    output logic [FLAG_W-1:0] flags_saved,
    output logic              int_active
);

    localparam int              CNT_W      = (VEC_LAT > 1) ? $clog2(VEC_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(VEC_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [PC_W-1:0]  VEC_ADDR  = PC_W'(VECTOR_ADDR);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PUSH    = 3'd1,
        S_VECTOR  = 3'd2,
        S_LOAD_PC = 3'd3,
        S_ACTIVE  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic              pending_q, pending_d;
    logic              intr_prev_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PC_W-1:0]   saved_pc_q, saved_pc_d;
    logic [FLAG_W-1:0] flags_saved_q, flags_saved_d;
    logic [PC_W-1:0]   pc_load_val_q, pc_load_val_d;
    logic              intr_edge;

    // A level held high produces exactly one request
    assign intr_edge = intr_in & ~intr_prev_q;

    assign saved_pc    = saved_pc_q;
    assign flags_saved = flags_saved_q;
    assign pc_load_val = pc_load_val_q;

    // State and datapath registers; reset aborts any sequence and drops the request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pending_q     <= 1'b0;
            intr_prev_q   <= 1'b0;
            cnt_q         <= '0;
            saved_pc_q    <= '0;
            flags_saved_q <= '0;
            pc_load_val_q <= '0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            intr_prev_q   <= intr_in;
            cnt_q         <= cnt_d;
            saved_pc_q    <= saved_pc_d;
            flags_saved_q <= flags_saved_d;
            pc_load_val_q <= pc_load_val_d;
        end
    end

    // Next-state and output decode for the entry/residency sequence
    always_comb begin
        state_d         = state_q;
        pending_d       = pending_q | intr_edge;
        cnt_d           = cnt_q;
        saved_pc_d      = saved_pc_q;
        flags_saved_d   = flags_saved_q;
        pc_load_val_d   = pc_load_val_q;
        is_hardware_int = 1'b0;
        stall_fetch     = 1'b0;
        mem_rd          = 1'b0;
        mem_addr        = '0;
        pc_load         = 1'b0;
        flags_restore   = 1'b0;
        int_active      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pending_q && instr_boundary && !ctrl_hazard) begin
                    saved_pc_d    = pc_in;
                    flags_saved_d = flags_in;
                    // A fresh edge arriving on the accept cycle stays queued
                    pending_d     = intr_edge;
                    state_d       = S_PUSH;
                end
            end
            S_PUSH: begin
                is_hardware_int = 1'b1;
                stall_fetch     = 1'b1;
                int_active      = 1'b1;
                cnt_d           = CNT_LOAD;
                state_d         = S_VECTOR;
            end
            S_VECTOR: begin
                mem_rd      = 1'b1;
                mem_addr    = VEC_ADDR;
                stall_fetch = 1'b1;
                int_active  = 1'b1;
                if (cnt_q == '0) begin
                    pc_load_val_d = mem_rdata;
                    state_d       = S_LOAD_PC;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_LOAD_PC: begin
                pc_load     = 1'b1;
                stall_fetch = 1'b1;
                int_active  = 1'b1;
                state_d     = S_ACTIVE;
            end
            S_ACTIVE: begin
                int_active = 1'b1;
                if (rti_commit) begin
                    flags_restore = 1'b1;
                    state_d       = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_int_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_int_sequencer
//  Description : Self-checking bench for int_sequencer. Two instances (vector
//                latency 1 and 3) share stimulus; a timeline model per
//                instance predicts every output each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_int_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        intr_in = 1'b0;
    logic        instr_boundary = 1'b0;
    logic        ctrl_hazard = 1'b0;
    logic        rti_commit = 1'b0;
    logic [31:0] pc_in = '0;
    logic [3:0]  flags_in = '0;
    logic [31:0] mem_rdata = '0;

    logic        a_hw, a_stall, a_rd, a_pl, a_fr, a_ia;
    logic [31:0] a_sp, a_addr, a_plv;
    logic [3:0]  a_fs;
    logic        b_hw, b_stall, b_rd, b_pl, b_fr, b_ia;
    logic [31:0] b_sp, b_addr, b_plv;
    logic [3:0]  b_fs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    int_sequencer #(.PC_W(32), .FLAG_W(4), .VECTOR_ADDR(1), .VEC_LAT(1)) u_dut_l1 (
        .clk(clk), .rst(rst), .intr_in(intr_in), .instr_boundary(instr_boundary),
        .ctrl_hazard(ctrl_hazard), .rti_commit(rti_commit), .pc_in(pc_in),
        .flags_in(flags_in), .mem_rdata(mem_rdata), .is_hardware_int(a_hw),
        .saved_pc(a_sp), .stall_fetch(a_stall), .mem_rd(a_rd), .mem_addr(a_addr),
        .pc_load(a_pl), .pc_load_val(a_plv), .flags_restore(a_fr),
        .flags_saved(a_fs), .int_active(a_ia)
    );

    int_sequencer #(.PC_W(32), .FLAG_W(4), .VECTOR_ADDR(1), .VEC_LAT(3)) u_dut_l3 (
        .clk(clk), .rst(rst), .intr_in(intr_in), .instr_boundary(instr_boundary),
        .ctrl_hazard(ctrl_hazard), .rti_commit(rti_commit), .pc_in(pc_in),
        .flags_in(flags_in), .mem_rdata(mem_rdata), .is_hardware_int(b_hw),
        .saved_pc(b_sp), .stall_fetch(b_stall), .mem_rd(b_rd), .mem_addr(b_addr),
        .pc_load(b_pl), .pc_load_val(b_plv), .flags_restore(b_fr),
        .flags_saved(b_fs), .int_active(b_ia)
    );

    wire [105:0] a_vec = {a_hw, a_stall, a_rd, a_pl, a_fr, a_ia, a_sp, a_fs, a_plv, a_addr};
    wire [105:0] b_vec = {b_hw, b_stall, b_rd, b_pl, b_fr, b_ia, b_sp, b_fs, b_plv, b_addr};

    // Reference model: ph = cycles elapsed since the accept edge (-1 when idle).
    // ph 1 is the push cycle, ph 2..L+1 the vector read, ph L+2 the PC load,
    // ph L+3 the handler body until RTI.
    int          m_ph[2]   = '{-1, -1};
    bit          m_pend[2] = '{1'b0, 1'b0};
    bit          m_prev[2] = '{1'b0, 1'b0};
    logic [31:0] m_sp[2]   = '{32'd0, 32'd0};
    logic [31:0] m_plv[2]  = '{32'd0, 32'd0};
    logic [3:0]  m_fs[2]   = '{4'd0, 4'd0};

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic logic [105:0] exp_vec(input int k);
        int   ph;
        int   l;
        logic rd;
        ph = m_ph[k];
        l  = lat(k);
        rd = (ph >= 2) && (ph <= l + 1);
        return {(ph == 1), (ph >= 1) && (ph <= l + 2), rd, (ph == l + 2),
                (ph == l + 3) && rti_commit, (ph >= 1),
                m_sp[k], m_fs[k], m_plv[k], rd ? 32'd1 : 32'd0};
    endfunction

    function automatic logic [105:0] got_vec(input int k);
        return (k == 0) ? a_vec : b_vec;
    endfunction

    // Model advance at every clock edge, cleared by reset
    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_ph[k]   <= -1;
                m_pend[k] <= 1'b0;
                m_prev[k] <= 1'b0;
                m_sp[k]   <= '0;
                m_plv[k]  <= '0;
                m_fs[k]   <= '0;
            end else begin
                m_prev[k] <= intr_in;
                if (m_ph[k] < 0) begin
                    if (m_pend[k] && instr_boundary && !ctrl_hazard) begin
                        m_sp[k]   <= pc_in;
                        m_fs[k]   <= flags_in;
                        m_ph[k]   <= 1;
                        m_pend[k] <= intr_in && !m_prev[k];
                    end else begin
                        m_pend[k] <= m_pend[k] | (intr_in & ~m_prev[k]);
                    end
                end else begin
                    m_pend[k] <= m_pend[k] | (intr_in & ~m_prev[k]);
                    if (m_ph[k] == lat(k) + 1) m_plv[k] <= mem_rdata;
                    if (m_ph[k] < lat(k) + 3) m_ph[k] <= m_ph[k] + 1;
                    else if (rti_commit) m_ph[k] <= -1;
                end
            end
        end
    end

    task automatic test_reset();
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (got_vec(k) !== 106'd0) begin
                errors++;
                $display("FAIL reset dut%0d got %h expected 0", k, got_vec(k));
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int a_st = 0, b_st = 0, a_hwn = 0, b_hwn = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            intr_in        = (c == 0);
            instr_boundary = (c == 1);
            pc_in          = 32'h40;
            flags_in       = 4'b1010;
            mem_rdata      = 32'h200;
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (got_vec(k) !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL basic dut%0d cyc %0d got %h expected %h", k, c, got_vec(k), exp_vec(k));
                end
            end
            a_st += int'(a_stall); b_st += int'(b_stall);
            a_hwn += int'(a_hw); b_hwn += int'(b_hw);
            if (a_hw) begin
                checks++;
                if (a_sp !== 32'h40 || c != 2) begin
                    errors++;
                    $display("FAIL basic_push saved_pc %h at cyc %0d, expected 40 at cyc 2", a_sp, c);
                end
            end
            if (a_pl) begin
                checks++;
                if (a_plv !== 32'h200 || a_fs !== 4'b1010 || c != 4) begin
                    errors++;
                    $display("FAIL basic_load val %h flags %b cyc %0d, expected 200 1010 cyc 4", a_plv, a_fs, c);
                end
            end
        end
        checks++;
        if (a_st != 3 || b_st != 5 || a_hwn != 1 || b_hwn != 1) begin
            errors++;
            $display("FAIL basic_stall stall %0d/%0d push %0d/%0d, expected 3/5 1/1", a_st, b_st, a_hwn, b_hwn);
        end
    endtask

    task automatic test_rti();
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            intr_in = 1'b0; instr_boundary = 1'b1;
            rti_commit = (c == 0);
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (got_vec(k) !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL rti dut%0d cyc %0d got %h expected %h", k, c, got_vec(k), exp_vec(k));
                end
            end
            checks++;
            if ({a_fr, b_fr, a_ia, b_ia} !== ((c == 0) ? 4'b1111 : 4'b0000) || a_fs !== 4'b1010) begin
                errors++;
                $display("FAIL rti_restore cyc %0d fr/ia %b%b%b%b flags %b", c, a_fr, b_fr, a_ia, b_ia, a_fs);
            end
        end
    endtask

    task automatic test_hazard();
        int first = -1;
        for (int c = 0; c < 16; c++) begin
            @(posedge clk); #1;
            intr_in        = (c == 0);
            instr_boundary = (c >= 1);
            ctrl_hazard    = (c >= 1 && c <= 3);
            rti_commit     = (c == 15);
            pc_in          = $urandom;
            flags_in       = 4'($urandom_range(0, 15));
            mem_rdata      = $urandom;
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (got_vec(k) !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL hazard dut%0d cyc %0d got %h expected %h", k, c, got_vec(k), exp_vec(k));
                end
            end
            if (a_hw && first < 0) first = c;
        end
        ctrl_hazard = 1'b0;
        checks++;
        if (first != 5) begin
            errors++;
            $display("FAIL hazard_defer push at cyc %0d, expected 5", first);
        end
    endtask

    task automatic test_no_nesting();
        int early = 0;
        for (int c = 0; c < 29; c++) begin
            @(posedge clk); #1;
            intr_in        = (c == 0 || c == 10);
            instr_boundary = 1'b1;
            rti_commit     = (c == 14 || c == 28);
            pc_in          = $urandom;
            flags_in       = 4'($urandom_range(0, 15));
            mem_rdata      = $urandom;
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (got_vec(k) !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL nest dut%0d cyc %0d got %h expected %h", k, c, got_vec(k), exp_vec(k));
                end
            end
            if (c >= 10 && c <= 15) early += int'(a_hw) + int'(b_hw);
            if (c == 16) begin
                checks++;
                if ({a_hw, b_hw} !== 2'b11) begin
                    errors++;
                    $display("FAIL nest_reentry push %b%b, expected 11", a_hw, b_hw);
                end
            end
        end
        checks++;
        if (early != 0) begin
            errors++;
            $display("FAIL nest_hold %0d pushes while active, expected 0", early);
        end
    endtask

    task automatic test_level_hold();
        int hwn = 0, frn = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            intr_in        = (c <= 9);
            instr_boundary = (c == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            rti_commit     = (c >= 14);
            pc_in          = $urandom;
            mem_rdata      = $urandom;
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (got_vec(k) !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL level dut%0d cyc %0d got %h expected %h", k, c, got_vec(k), exp_vec(k));
                end
            end
            hwn += int'(a_hw) + int'(b_hw);
            if (c >= 15) frn += int'(a_fr) + int'(b_fr);
        end
        rti_commit = 1'b0;
        checks++;
        if (hwn != 2 || frn != 0) begin
            errors++;
            $display("FAIL level_once pushes %0d restores %0d, expected 2 0", hwn, frn);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 6) == 0) intr_in = ~intr_in;
            instr_boundary = 1'($urandom_range(0, 1));
            ctrl_hazard    = ($urandom_range(0, 3) == 0);
            rti_commit     = ($urandom_range(0, 5) == 0);
            pc_in          = $urandom;
            flags_in       = 4'($urandom_range(0, 15));
            mem_rdata      = $urandom;
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (got_vec(k) !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL random dut%0d cyc %0d got %h expected %h", k, c, got_vec(k), exp_vec(k));
                end
            end
        end
    endtask

    task automatic test_async_reset();
        int after = 0;
        @(posedge clk); #1;
        rst = 1'b1; intr_in = 1'b0; ctrl_hazard = 1'b0; rti_commit = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            intr_in        = (c == 0 || c == 2);
            instr_boundary = (c == 1);
            mem_rdata      = $urandom;
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (got_vec(k) !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL areset dut%0d cyc %0d got %h expected %h", k, c, got_vec(k), exp_vec(k));
                end
            end
        end
        checks++;
        if (b_rd !== 1'b1) begin
            errors++;
            $display("FAIL areset_vector mem_rd %b, expected 1", b_rd);
        end
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (got_vec(k) !== 106'd0) begin
                errors++;
                $display("FAIL areset_zero dut%0d got %h expected 0", k, got_vec(k));
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            instr_boundary = 1'b1;
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (got_vec(k) !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL areset_after dut%0d cyc %0d got %h expected %h", k, c, got_vec(k), exp_vec(k));
                end
            end
            after += int'(a_hw) + int'(b_hw) + int'(a_pl) + int'(b_pl);
        end
        checks++;
        if (after != 0) begin
            errors++;
            $display("FAIL areset_lost %0d push/load pulses after reset, expected 0", after);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rti();
        test_hazard();
        test_no_nesting();
        test_level_hold();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
